// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler: round-robin front end sharing one iterative square-root core among NREQ requesters.
// Latency: accept -> rsp_valid is (core cycles + 1); N/2+1 cycles with the standard core.
// Backpressure: one op in flight; no new grant until the owner takes its response (rsp_ready).
// Optional macro SQRT_RR_SCHEDULER_TIMEOUT_EN adds a RUN watchdog that returns all-ones with rsp_err=1.
module sqrt_rr_scheduler #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TMO_CYC = N/2 + 4
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N/2-1:0]    rsp_root,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_reset,
  output logic [N-1:0]      core_num,
  input  logic              core_done,
  input  logic [N/2-1:0]    core_root
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Reject parameter combinations the arbiter and root width cannot support.
  if ((N % 2) != 0 || N < 4 || NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_bad_param
    $error("sqrt_rr_scheduler: unsupported parameter set");
  end

  logic [1:0]     state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [N-1:0]   num_q, num_d;
  logic [N/2-1:0] root_q, root_d;
  logic           crst_q, crst_d;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]  gnt_idx;
  logic [N-1:0]   gnt_data;

`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Round-robin search starting just after the last owner, wrapping modulo NREQ.
  always_comb begin
    int      cand;
    logic    found;
    logic [IW-1:0] cidx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IW'(cand);
      if (!found && req_valid[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        gnt_idx     = cidx;
      end
    end
  end

  // Select the granted requester's operand slice with constant indices only.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) gnt_data = req_data[k*N +: N];
    end
  end

  // Response valid is the owner's bit while the result waits for pickup.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = (state_q == S_RESP) && (owner_q == IW'(k));
    end
  end

  assign req_ready  = (state_q == S_IDLE) ? grant : '0;
  assign busy       = (state_q != S_IDLE);
  assign core_reset = crst_q;
  assign core_num   = num_q;
  assign rsp_root   = root_q;

  // Next-state logic: accept in IDLE, wait for the core in RUN, hand off in RESP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    num_d   = num_q;
    root_d  = root_q;
    crst_d  = crst_q;
`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        crst_d = 1'b1;
        if (|grant) begin
          num_d   = gnt_data;
          owner_d = gnt_idx;
          ptr_d   = gnt_idx;
          crst_d  = 1'b0;
          state_d = S_RUN;
`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (core_done) begin
          root_d  = core_root;
          crst_d  = 1'b1;
          state_d = S_RESP;
`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          root_d  = '1;
          err_d   = 1'b1;
          crst_d  = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d   = tmo_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        crst_d = 1'b1;
        if (|(rsp_valid & rsp_ready)) state_d = S_IDLE;
      end
      default: begin
        crst_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      num_q   <= '0;
      root_q  <= '0;
      crst_q  <= 1'b1;
`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      num_q   <= num_d;
      root_q  <= root_d;
      crst_q  <= crst_d;
`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// tb_sqrt_rr_scheduler: directed bench with a behavioural iterative sqrt core.
// Core model: registered done pulse 16 cycles after core_reset drops.
// Responses are accepted by the bench only when a vector asks for it.
module tb_sqrt_rr_scheduler;

  logic         Clock;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [15:0]  rsp_root;
  logic         rsp_err;
  logic         busy;
  logic         core_reset;
  logic [31:0]  core_num;
  logic         core_done;
  logic [15:0]  core_root;

  logic         core_kill;
  int           cc;
  int           n_chk;
  int           n_err;

  sqrt_rr_scheduler #(.N(32), .NREQ(4)) dut (
    .Clock(Clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_root(rsp_root),
    .rsp_err(rsp_err), .busy(busy), .core_reset(core_reset),
    .core_num(core_num), .core_done(core_done), .core_root(core_root)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint unsigned r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[15:0];
  endfunction

  // Behavioural core: 16 iterations after reset release, then a one-cycle done.
  always @(posedge Clock) begin
    if (core_reset) begin
      cc        <= 0;
      core_done <= 1'b0;
      core_root <= '0;
    end else begin
      if (cc < 16) cc <= cc + 1;
      core_done <= (cc == 15) && !core_kill;
      if (cc == 15) core_root <= isqrt(core_num);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Waits for any rsp_valid bit; returns cycles since the accept edge (61 if never).
  task automatic wait_rsp(output int c);
    c = 0;
    while (c <= 60) begin
      step();
      c++;
      if (rsp_valid != 4'b0) break;
    end
  endtask

  task automatic do_req(input int k, input logic [31:0] op, input logic [15:0] er,
                        input int el, input logic ee, input string tag);
    int c;
    req_data[k*32 +: 32] = op;
    req_valid = 4'(1 << k);
    #1;
    chk({tag, ":gnt"}, 64'(req_ready), 64'(1 << k));
    step();
    req_valid = 4'b0;
    #1;
    chk({tag, ":rdy_off"}, 64'(req_ready), 64'd0);
    chk({tag, ":num"}, 64'(core_num), 64'(op));
    chk({tag, ":crst_run"}, 64'(core_reset), 64'd0);
    wait_rsp(c);
    chk({tag, ":lat"}, 64'(c), 64'(el));
    chk({tag, ":vld"}, 64'(rsp_valid), 64'(1 << k));
    chk({tag, ":root"}, 64'(rsp_root), 64'(er));
    chk({tag, ":err"}, 64'(rsp_err), 64'(ee));
    chk({tag, ":crst_resp"}, 64'(core_reset), 64'd1);
    rsp_ready = 4'(1 << k);
    step();
    rsp_ready = 4'b0;
    chk({tag, ":busy_done"}, 64'(busy), 64'd0);
    chk({tag, ":vld_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int c;
    logic [3:0]  exp_g [5];
    logic [15:0] exp_r [5];
    n_chk = 0;
    n_err = 0;
    core_kill = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
    do_reset();

    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:crst", 64'(core_reset), 64'd1);
    chk("rst:vld", 64'(rsp_valid), 64'd0);
    chk("rst:root", 64'(rsp_root), 64'd0);
    chk("rst:err", 64'(rsp_err), 64'd0);
    chk("rst:num", 64'(core_num), 64'd0);
    chk("rst:rdy", 64'(req_ready), 64'd0);

    do_req(0, 32'd144, 16'd12, 17, 1'b0, "single");

    do_req(2, 32'd0,          16'd0,     17, 1'b0, "b_zero");
    do_req(2, 32'hFFFF_FFFF,  16'd65535, 17, 1'b0, "b_max");
    do_req(2, 32'h0001_0000,  16'd256,   17, 1'b0, "b_2p16");
    do_req(2, 32'd65535,      16'd255,   17, 1'b0, "b_65535");

    // All four valid from reset: order 0,1,2,3,0.
    do_reset();
    req_data  = {32'd16, 32'd9, 32'd4, 32'd1};
    req_valid = 4'hF;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1};
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d:gnt", i), 64'(req_ready), 64'(exp_g[i]));
      step();
      wait_rsp(c);
      chk($sformatf("rr%0d:lat", i), 64'(c), 64'd17);
      chk($sformatf("rr%0d:vld", i), 64'(rsp_valid), 64'(exp_g[i]));
      chk($sformatf("rr%0d:root", i), 64'(rsp_root), 64'(exp_r[i]));
      rsp_ready = exp_g[i];
      step();
      rsp_ready = 4'b0;
    end
    req_valid = 4'b0;
    step();
    step();
    rsp_ready = 4'hF;
    step();
    rsp_ready = 4'b0;

    // Backpressure on requester 1 while requester 3 waits.
    do_reset();
    req_data  = {32'd400, 32'd0, 32'd10000, 32'd0};
    req_valid = 4'b1010;
    #1;
    chk("bp:gnt1", 64'(req_ready), 64'b0010);
    step();
    wait_rsp(c);
    chk("bp:lat", 64'(c), 64'd17);
    rsp_ready = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d:root", i), 64'(rsp_root), 64'd100);
      chk($sformatf("bp%0d:rdy", i), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d:vld", i), 64'(rsp_valid), 64'b0010);
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = 4'b0;
    chk("bp:gnt3", 64'(req_ready), 64'b1000);
    step();
    req_valid = 4'b0;
    wait_rsp(c);
    chk("bp3:lat", 64'(c), 64'd17);
    chk("bp3:vld", 64'(rsp_valid), 64'b1000);
    chk("bp3:root", 64'(rsp_root), 64'd20);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = 4'b0;

    // Reset 8 cycles into RUN, then a clean request.
    req_data[31:0] = 32'd1000000;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid:busy_run", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid:busy", 64'(busy), 64'd0);
    chk("mid:crst", 64'(core_reset), 64'd1);
    chk("mid:vld", 64'(rsp_valid), 64'd0);
    chk("mid:num", 64'(core_num), 64'd0);
    do_req(0, 32'd49, 16'd7, 17, 1'b0, "after_rst");

`ifdef SQRT_RR_SCHEDULER_TIMEOUT_EN
    core_kill = 1'b1;
    do_req(0, 32'd144, 16'hFFFF, 20, 1'b1, "tmo");
    core_kill = 1'b0;
    do_req(1, 32'd81, 16'd9, 17, 1'b0, "post_tmo");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
